// File: rtl/wb_stage_if.sv
// Writeback stage bus: ALU result, memory-result handshake, register-file write port
// and hazard/occupancy status.
interface wb_stage_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            rf_we;
    logic [4:0]      rf_rw;
    logic [XLEN-1:0] rf_din;
    logic [31:0]     pend_mask;
    logic [CW-1:0]   fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, rf_we, rf_rw, rf_din, pend_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, rf_we, rf_rw, rf_din, pend_mask, fifo_count
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: merges unstallable ALU results with FIFO-buffered memory results
// into one register-file write per cycle, killing buffered writes overtaken by the ALU.
module wb_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       ent_rd   [DEPTH];
    logic [XLEN-1:0]  ent_data [DEPTH];
    logic [DEPTH-1:0] ent_live;
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [31:0]      mask;

    logic alu_wr, pop, xfer, push;

    assign alu_wr = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign pop    = !alu_wr && (count != '0);
    // Credit comes only from registered occupancy; a same-cycle pop does not open a slot.
    assign bus.mem_ready  = reset && (count < CW'(DEPTH));
    assign xfer           = bus.mem_valid && bus.mem_ready;
    assign push           = xfer && (bus.mem_rd != 5'd0);
    assign bus.fifo_count = count;
    assign bus.pend_mask  = mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_live[i]) mask[ent_rd[i]] = 1'b1;
        mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_live   <= '0;
            bus.rf_we  <= 1'b0;
            bus.rf_rw  <= 5'd0;
            bus.rf_din <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i]   <= 5'd0;
                ent_data[i] <= '0;
            end
        end else begin
            // Kill only resident entries; the tail write below runs later and wins,
            // so a same-cycle beat to the same register stays live.
            for (int i = 0; i < DEPTH; i++)
                if (alu_wr && ent_rd[i] == bus.alu_rd) ent_live[i] <= 1'b0;

            if (pop) begin
                ent_live[head] <= 1'b0;
                head           <= head + AW'(1);
            end

            if (push) begin
                ent_rd[tail]   <= bus.mem_rd;
                ent_data[tail] <= bus.mem_data;
                ent_live[tail] <= 1'b1;
                tail           <= tail + AW'(1);
            end

            count <= count + CW'(push) - CW'(pop);

            if (alu_wr) begin
                bus.rf_we  <= 1'b1;
                bus.rf_rw  <= bus.alu_rd;
                bus.rf_din <= bus.alu_data;
            end else if (pop) begin
                bus.rf_we <= ent_live[head];
                if (ent_live[head]) begin
                    bus.rf_rw  <= ent_rd[head];
                    bus.rf_din <= ent_data[head];
                end
            end else begin
                bus.rf_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: queue-based reference model checked every cycle,
// plus hand-computed expectations along the test plan.
module tb_wb_stage;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    wb_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            live;
    } ent_t;

    ent_t            q[$];
    logic            m_we  = 1'b0;
    logic [4:0]      m_rw  = 5'd0;
    logic [XLEN-1:0] m_din = '0;
    logic [XLEN-1:0] regfile [32];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].live && q[i].rd != 5'd0) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    // Reference model: the FIFO is just a queue of {rd,data,live}.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_we  = 1'b0;
            m_rw  = 5'd0;
            m_din = '0;
        end else begin
            int  sz;
            bit  ready;
            ent_t e;
            sz    = q.size();
            ready = (sz < DEPTH);
            if (m_we) regfile[m_rw] = m_din;
            if (bus.alu_valid && bus.alu_rd != 5'd0) begin
                foreach (q[i]) if (q[i].rd == bus.alu_rd) q[i].live = 1'b0;
                m_we  = 1'b1;
                m_rw  = bus.alu_rd;
                m_din = bus.alu_data;
            end else if (sz > 0) begin
                e    = q.pop_front();
                m_we = e.live;
                if (e.live) begin
                    m_rw  = e.rd;
                    m_din = e.data;
                end
            end else begin
                m_we = 1'b0;
            end
            if (bus.mem_valid && ready && bus.mem_rd != 5'd0)
                q.push_back('{rd: bus.mem_rd, data: bus.mem_data, live: 1'b1});
        end
    end

    always @(negedge clk) begin
        chk("rf_we",      {63'd0, bus.rf_we}, {63'd0, m_we});
        chk("rf_rw",      {59'd0, bus.rf_rw}, {59'd0, m_rw});
        chk("rf_din",     bus.rf_din, m_din);
        chk("pend_mask",  {32'd0, bus.pend_mask}, {32'd0, model_mask()});
        chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        chk("mem_ready",  {63'd0, bus.mem_ready}, {63'd0, reset && (q.size() < DEPTH)});
    end

    task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [63:0] md);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        foreach (regfile[i]) regfile[i] = '0;
        idle();
        step();
        step();
        chk("rst_we",    {63'd0, bus.rf_we}, 64'd0);
        chk("rst_ready", {63'd0, bus.mem_ready}, 64'd0);
        reset = 1'b1;
        #1;
        chk("ready_after_rst", {63'd0, bus.mem_ready}, 64'd1);

        // ALU write to x5
        drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        step();
        chk("alu_we",  {63'd0, bus.rf_we}, 64'd1);
        chk("alu_rw",  {59'd0, bus.rf_rw}, 64'd5);
        chk("alu_din", bus.rf_din, 64'h1234);
        idle();
        step();
        chk("alu_we_next", {63'd0, bus.rf_we}, 64'd0);

        // Single memory beat to x7
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hDEAD_BEEF);
        step();
        chk("mem_pend7", {32'd0, bus.pend_mask}, 64'h80);
        chk("mem_cnt1",  64'(bus.fifo_count), 64'd1);
        idle();
        step();
        chk("mem_we",   {63'd0, bus.rf_we}, 64'd1);
        chk("mem_rw",   {59'd0, bus.rf_rw}, 64'd7);
        chk("mem_din",  bus.rf_din, 64'hDEAD_BEEF);
        chk("mem_pend", {32'd0, bus.pend_mask}, 64'd0);
        chk("mem_cnt0", 64'(bus.fifo_count), 64'd0);

        // Fill under continuous ALU writes, then drain in order
        for (int r = 2; r <= 5; r++) begin
            drive(1'b1, 5'd1, 64'(r), 1'b1, 5'(r), 64'h200 + 64'(r));
            step();
        end
        chk("full_cnt",   64'(bus.fifo_count), 64'd4);
        chk("full_ready", {63'd0, bus.mem_ready}, 64'd0);
        drive(1'b1, 5'd1, 64'h99, 1'b1, 5'd6, 64'h206);
        step();
        chk("held_cnt",  64'(bus.fifo_count), 64'd4);
        chk("held_pend", {32'd0, bus.pend_mask}, 64'h3C);
        idle();
        step();
        chk("drain_rw2",   {59'd0, bus.rf_rw}, 64'd2);
        chk("drain_ready", {63'd0, bus.mem_ready}, 64'd1);
        for (int r = 3; r <= 5; r++) begin
            step();
            chk("drain_rw", {59'd0, bus.rf_rw}, 64'(r));
            chk("drain_din", bus.rf_din, 64'h200 + 64'(r));
        end
        step();
        chk("drain_done", {63'd0, bus.rf_we}, 64'd0);

        // WAW kill of buffered x9
        drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd9, 64'hAA);
        step();
        chk("waw_pend9", {32'd0, bus.pend_mask}, 64'h200);
        drive(1'b1, 5'd9, 64'hBB, 1'b0, 5'd0, 64'd0);
        step();
        chk("waw_pend_clr", {32'd0, bus.pend_mask}, 64'd0);
        chk("waw_cnt_dead", 64'(bus.fifo_count), 64'd1);
        idle();
        step();
        chk("waw_dead_we", {63'd0, bus.rf_we}, 64'd0);
        step();
        chk("waw_rf9", regfile[9], 64'hBB);

        // Same-cycle push to the killed register stays live
        drive(1'b1, 5'd2, 64'h1, 1'b1, 5'd4, 64'h41);
        step();
        drive(1'b1, 5'd4, 64'h4A, 1'b1, 5'd4, 64'h4B);
        step();
        chk("young_cnt",  64'(bus.fifo_count), 64'd2);
        chk("young_pend", {32'd0, bus.pend_mask}, 64'h10);
        idle();
        step();
        chk("young_dead_we", {63'd0, bus.rf_we}, 64'd0);
        step();
        chk("young_din", bus.rf_din, 64'h4B);

        // alu_rd=0 does not take the slot; mem_rd=0 beat is swallowed
        drive(1'b1, 5'd1, 64'h5, 1'b1, 5'd3, 64'h33);
        step();
        drive(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'd0);
        step();
        chk("x0alu_we",  {63'd0, bus.rf_we}, 64'd1);
        chk("x0alu_rw",  {59'd0, bus.rf_rw}, 64'd3);
        chk("x0alu_din", bus.rf_din, 64'h33);
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h77);
        step();
        chk("x0mem_cnt", 64'(bus.fifo_count), 64'd0);
        chk("x0mem_we",  {63'd0, bus.rf_we}, 64'd0);

        // Reset mid-drain
        for (int r = 10; r <= 12; r++) begin
            drive(1'b1, 5'd1, 64'h7, 1'b1, 5'(r), 64'(r));
            step();
        end
        idle();
        step();
        chk("pre_rst_rw", {59'd0, bus.rf_rw}, 64'd10);
        reset = 1'b0;
        #1;
        chk("mid_rst_we",   {63'd0, bus.rf_we}, 64'd0);
        chk("mid_rst_din",  bus.rf_din, 64'd0);
        chk("mid_rst_cnt",  64'(bus.fifo_count), 64'd0);
        chk("mid_rst_pend", {32'd0, bus.pend_mask}, 64'd0);
        step();
        reset = 1'b1;
        step();
        step();
        chk("post_rst_we",  {63'd0, bus.rf_we}, 64'd0);
        chk("post_rst_cnt", 64'(bus.fifo_count), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
